// File: rtl/imem_loader_if.sv
// Host load stream between the program source and imem_loader.
//   load_valid  host word valid
//   load_ready  loader can accept a word
//   load_data   9-bit machine word
//   load_last   final word of the program
// master: host side; slave: loader side.
interface imem_loader_if #(
    parameter int unsigned INSTR_W = 9
);
    logic               load_valid;
    logic               load_ready;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader and run sequencer for the single-cycle 9-bit core.
// Streams machine words from the host into instruction memory starting at
// address 0, releases the core from its start reset, waits for done and
// reports program length, run cycle count and error status.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   host (slave)          load_valid/load_ready/load_data/load_last stream
//   imem_wr_en/addr/data  registered instruction-memory write port
//   core_start            high holds the core in reset
//   core_done             core finished, sampled only while running
//   busy                  loader not idle
//   complete              one-cycle pulse when a run ends
//   prog_len              number of words loaded
//   run_cycles            cycles spent running (saturating)
//   err_overflow          program truncated at 2^ADDR_W words
//   err_timeout           run aborted after TIMEOUT cycles
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned INSTR_W   = 9,
    parameter int unsigned START_CYC = 2,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    imem_loader_if.slave       host,
    output logic               imem_wr_en,
    output logic [ADDR_W-1:0]  imem_wr_addr,
    output logic [INSTR_W-1:0] imem_wr_data,
    output logic               core_start,
    input  logic               core_done,
    output logic               busy,
    output logic               complete,
    output logic [ADDR_W:0]    prog_len,
    output logic [15:0]        run_cycles,
    output logic               err_overflow,
    output logic               err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [15:0] START_LAST = 16'(START_CYC - 1);

    state_t              state;
    state_t              state_d;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   eff_ptr;
    logic [15:0]         start_cnt;
    logic [15:0]         run_inc;
    logic                accept;
    logic                first_word;
    logic                ovf_hit;
    logic                last_word;
    logic                timeout_hit;

    // The first accept always writes address 0, whatever the pointer holds.
    assign first_word  = (state == S_IDLE);
    assign eff_ptr     = first_word ? '0 : wr_ptr;
    assign accept      = host.load_valid & host.load_ready;
    assign ovf_hit     = accept & ~host.load_last & (eff_ptr == '1);
    assign last_word   = accept & (host.load_last | (eff_ptr == '1));
    assign run_inc     = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
    assign timeout_hit = (run_inc >= TIMEOUT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d         = state;
        host.load_ready = 1'b0;
        core_start      = 1'b1;
        complete        = 1'b0;
        case (state)
            S_IDLE: begin
                host.load_ready = 1'b1;
                if (accept) begin
                    state_d = last_word ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                host.load_ready = 1'b1;
                if (last_word) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (start_cnt == START_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                core_start = 1'b0;
                if (core_done || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                core_start = 1'b0;
                complete   = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            wr_ptr       <= '0;
            start_cnt    <= '0;
            busy         <= 1'b0;
            prog_len     <= '0;
            run_cycles   <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            busy       <= (state_d != S_IDLE);
            imem_wr_en <= accept;

            if (accept) begin
                imem_wr_addr <= eff_ptr;
                imem_wr_data <= host.load_data;
                wr_ptr       <= eff_ptr + 1'b1;
                prog_len     <= first_word ? (ADDR_W+1)'(1) : prog_len + 1'b1;
            end

            // A new program clears the previous run's status; overflow can
            // only arise on the first word when the address space is 1 deep.
            if (accept && first_word) begin
                run_cycles   <= '0;
                err_timeout  <= 1'b0;
                err_overflow <= ovf_hit;
            end else if (ovf_hit) begin
                err_overflow <= 1'b1;
            end

            if (state == S_START) begin
                start_cnt <= start_cnt + 16'd1;
            end else begin
                start_cnt <= '0;
            end

            if (state == S_RUN) begin
                run_cycles <= run_inc;
                // done in the same cycle as the timeout takes precedence
                if (!core_done && timeout_hit) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the stimulus pushes expected writes and
// expected run completions; a monitor pops and compares them whenever the
// DUT presents an instruction-memory write or a complete pulse.
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned INSTR_W   = 9;
    localparam int unsigned START_CYC = 2;
    localparam logic [15:0] TMO       = 16'd20;

    typedef struct packed {
        logic [10:0] len;
        logic [15:0] cyc;
        logic        ovf;
        logic        tmo;
    } cpl_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.INSTR_W(INSTR_W)) host ();

    logic               imem_wr_en;
    logic [ADDR_W-1:0]  imem_wr_addr;
    logic [INSTR_W-1:0] imem_wr_data;
    logic               core_start;
    logic               core_done;
    logic               busy;
    logic               complete;
    logic [ADDR_W:0]    prog_len;
    logic [15:0]        run_cycles;
    logic               err_overflow;
    logic               err_timeout;

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .START_CYC(START_CYC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (host),
        .imem_wr_en  (imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .core_start  (core_start),
        .core_done   (core_done),
        .busy        (busy),
        .complete    (complete),
        .prog_len    (prog_len),
        .run_cycles  (run_cycles),
        .err_overflow(err_overflow),
        .err_timeout (err_timeout)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [18:0] wq[$];
    cpl_t        cq[$];
    logic [9:0]  exp_ptr;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void exp_cpl(input int len, input int cyc, input bit ovf, input bit tmo);
        cpl_t c;
        c.len = 11'(len);
        c.cyc = 16'(cyc);
        c.ovf = ovf;
        c.tmo = tmo;
        cq.push_back(c);
    endfunction

    // Monitor: every write and every complete pulse must match the oldest
    // expectation in its queue.
    logic [18:0] mon_w;
    cpl_t        mon_c;
    always @(negedge clk) begin
        if (reset) begin
            if (imem_wr_en) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_unexpected: write addr 0x%0h data 0x%0h, none expected",
                             imem_wr_addr, imem_wr_data);
                end else begin
                    mon_w = wq.pop_front();
                    chk("wr_addr", 32'(imem_wr_addr), 32'(mon_w[18:9]));
                    chk("wr_data", 32'(imem_wr_data), 32'(mon_w[8:0]));
                end
            end
            if (complete) begin
                if (cq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cpl_unexpected: complete pulse, none expected");
                end else begin
                    mon_c = cq.pop_front();
                    chk("cpl_prog_len", 32'(prog_len), 32'(mon_c.len));
                    chk("cpl_run_cycles", 32'(run_cycles), 32'(mon_c.cyc));
                    chk("cpl_err_overflow", 32'(err_overflow), 32'(mon_c.ovf));
                    chk("cpl_err_timeout", 32'(err_timeout), 32'(mon_c.tmo));
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_core_start"}, 32'(core_start), 32'd1);
        chk({tag, "_load_ready"}, 32'(host.load_ready), 32'd1);
        chk({tag, "_wr_en"}, 32'(imem_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(imem_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(imem_wr_data), 32'd0);
        chk({tag, "_complete"}, 32'(complete), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_prog_len"}, 32'(prog_len), 32'd0);
        chk({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
        chk({tag, "_err_overflow"}, 32'(err_overflow), 32'd0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    // Present one word and hold it until accepted; returns on the negedge
    // after the accepting edge, with load_valid still high.
    task automatic send(input logic [8:0] d, input logic last);
        int unsigned guard = 0;
        host.load_valid = 1'b1;
        host.load_data  = d;
        host.load_last  = last;
        while (!host.load_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!host.load_ready) begin
            chk("send_ready_wait", 32'(host.load_ready), 32'd1);
        end else begin
            wq.push_back({exp_ptr, d});
            exp_ptr++;
        end
        @(negedge clk);
    endtask

    task automatic wait_run(input string tag);
        int unsigned guard = 0;
        while (core_start && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_run_entry"}, 32'(core_start), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_idle_entry"}, 32'(busy), 32'd0);
    endtask

    initial begin
        host.load_valid = 1'b0;
        host.load_data  = '0;
        host.load_last  = 1'b0;
        core_done       = 1'b0;
        exp_ptr         = '0;

        #1 reset = 1'b0;
        #1 check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Three-word load, valid held high
        exp_ptr = '0;
        send(9'h1A5, 1'b0);
        send(9'h0FF, 1'b0);
        send(9'h100, 1'b1);
        host.load_valid = 1'b0;
        host.load_last  = 1'b0;
        chk("t1_prog_len", 32'(prog_len), 32'd3);
        chk("t1_start_hi0", 32'(core_start), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready_lo", 32'(host.load_ready), 32'd0);
        @(negedge clk);
        chk("t1_start_hi1", 32'(core_start), 32'd1);
        @(negedge clk);
        chk("t1_start_fall", 32'(core_start), 32'd0);

        // Run with done five cycles after core_start falls
        repeat (5) @(negedge clk);
        core_done = 1'b1;
        exp_cpl(3, 6, 1'b0, 1'b0);
        @(negedge clk);
        core_done = 1'b0;
        chk("t2_done_start_lo", 32'(core_start), 32'd0);
        @(negedge clk);
        chk("t2_idle_start", 32'(core_start), 32'd1);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_idle_complete", 32'(complete), 32'd0);
        chk("t2_hold_run_cycles", 32'(run_cycles), 32'd6);
        chk("t2_hold_prog_len", 32'(prog_len), 32'd3);

        // Single word, bursty host
        exp_ptr = '0;
        host.load_data  = 9'h0AA;
        host.load_last  = 1'b1;
        host.load_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t3_idle_ready", 32'(host.load_ready), 32'd1);
        end
        send(9'h0AA, 1'b1);
        host.load_valid = 1'b0;
        chk("t3_prog_len", 32'(prog_len), 32'd1);
        chk("t3_run_cleared", 32'(run_cycles), 32'd0);
        for (int i = 0; i < 2; i++) begin
            host.load_valid = (i == 0);
            chk("t3_ready_lo", 32'(host.load_ready), 32'd0);
            @(negedge clk);
        end
        host.load_valid = 1'b0;
        wait_run("t3");
        core_done = 1'b1;
        exp_cpl(1, 1, 1'b0, 1'b0);
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);

        // Overflow: 1025 words, no last
        exp_ptr = '0;
        for (int i = 0; i < 1024; i++) begin
            send(9'(i * 5 + 7), 1'b0);
        end
        host.load_data  = 9'h155;
        host.load_last  = 1'b0;
        host.load_valid = 1'b1;
        chk("t4_err_overflow", 32'(err_overflow), 32'd1);
        chk("t4_prog_len", 32'(prog_len), 32'd1024);
        for (int i = 0; i < 2; i++) begin
            chk("t4_start_ready_lo", 32'(host.load_ready), 32'd0);
            @(negedge clk);
        end
        chk("t4_run_start_lo", 32'(core_start), 32'd0);
        chk("t4_run_ready_lo", 32'(host.load_ready), 32'd0);
        core_done = 1'b1;
        exp_cpl(1024, 1, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_done_ready_lo", 32'(host.load_ready), 32'd0);
        core_done       = 1'b0;
        host.load_valid = 1'b0;
        @(negedge clk);
        chk("t4_idle_ready_hi", 32'(host.load_ready), 32'd1);
        chk("t4_hold_overflow", 32'(err_overflow), 32'd1);

        // Timeout with done held low
        exp_ptr = '0;
        send(9'h033, 1'b1);
        host.load_valid = 1'b0;
        chk("t5a_overflow_cleared", 32'(err_overflow), 32'd0);
        wait_run("t5a");
        exp_cpl(1, 20, 1'b0, 1'b1);
        wait_idle("t5a");
        chk("t5a_err_timeout", 32'(err_timeout), 32'd1);
        chk("t5a_run_cycles", 32'(run_cycles), 32'd20);

        // done on the timeout cycle wins
        exp_ptr = '0;
        send(9'h034, 1'b1);
        host.load_valid = 1'b0;
        chk("t5b_timeout_cleared", 32'(err_timeout), 32'd0);
        wait_run("t5b");
        repeat (19) @(negedge clk);
        chk("t5b_cyc19", 32'(run_cycles), 32'd19);
        core_done = 1'b1;
        exp_cpl(1, 20, 1'b0, 1'b0);
        @(negedge clk);
        core_done = 1'b0;
        chk("t5b_complete", 32'(complete), 32'd1);
        @(negedge clk);
        chk("t5b_err_timeout", 32'(err_timeout), 32'd0);
        chk("t5b_run_cycles", 32'(run_cycles), 32'd20);

        // Reset during RUN
        exp_ptr = '0;
        send(9'h001, 1'b0);
        send(9'h002, 1'b0);
        send(9'h003, 1'b1);
        host.load_valid = 1'b0;
        wait_run("t6");
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals("rst_run");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset during LOAD with a write in the registered stage
        exp_ptr = '0;
        send(9'h0C1, 1'b0);
        send(9'h0C2, 1'b0);
        host.load_data = 9'h0C3;
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_reset_vals("rst_load");
        @(negedge clk);
        host.load_valid = 1'b0;
        host.load_last  = 1'b0;
        reset           = 1'b1;
        chk("t6_wq_empty", 32'(wq.size()), 32'd0);
        wq.delete();
        cq.delete();
        @(negedge clk);

        // New load after release starts at address 0
        exp_ptr = '0;
        send(9'h0C4, 1'b1);
        host.load_valid = 1'b0;
        chk("t6_prog_len", 32'(prog_len), 32'd1);
        wait_run("t6b");
        core_done = 1'b1;
        exp_cpl(1, 1, 1'b0, 1'b0);
        @(negedge clk);
        core_done = 1'b0;
        repeat (3) @(negedge clk);

        chk("end_wq_empty", 32'(wq.size()), 32'd0);
        chk("end_cq_empty", 32'(cq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side program loader and run sequencer for the single-cycle 9-bit core. It is the writer end of the instruction-memory interface the core's PC reads from. It accepts a stream of 9-bit machine words over a valid/ready handshake and writes them to consecutive instruction-memory addresses from 0. It then releases the core from its `start` reset, waits for `done`, and reports the program length, the run cycle count and error status.

## Interface

Parameters:
- `ADDR_W`, 10, instruction address width; matches the 10-bit PC.
- `INSTR_W`, 9, machine word width.
- `START_CYC`, 2, cycles `core_start` stays high after the last write, minimum 1.
- `TIMEOUT`, 16'hFFFF, maximum run cycles before the run is aborted.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  host word valid.
- `load_ready`  out  1  loader can accept a word.
- `load_data`  in  INSTR_W  machine word.
- `load_last`  in  1  marks the final word of the program.
- `imem_wr_en`  out  1  instruction-memory write strobe.
- `imem_wr_addr`  out  ADDR_W  write address.
- `imem_wr_data`  out  INSTR_W  write data.
- `core_start`  out  1  drives the core's `start` input; high holds the core in reset.
- `core_done`  in  1  the core's `done` output.
- `busy`  out  1  state is not IDLE.
- `complete`  out  1  one-cycle pulse when a run ends.
- `prog_len`  out  ADDR_W+1  number of words loaded.
- `run_cycles`  out  16  cycles spent in RUN.
- `err_overflow`  out  1  program was truncated at 2^ADDR_W words.
- `err_timeout`  out  1  run was aborted by `TIMEOUT`.

## Operation

- States: IDLE, LOAD, START, RUN, DONE.
- `load_ready` is 1 in IDLE and LOAD, 0 otherwise. A word is accepted on a cycle where `load_valid & load_ready`.
- IDLE:
  - On an accepted word, go to LOAD.
  - The same accept clears `prog_len`, `run_cycles`, `err_overflow` and `err_timeout`, and resets the write pointer to 0.
- LOAD:
  - Each accepted word is written at the pointer, then the pointer and `prog_len` increment.
  - An accept with `load_last`=1 goes to START. This includes an accept taken in IDLE, giving `prog_len`=1.
  - If a word is accepted at pointer 2^ADDR_W−1 with `load_last`=0, it is treated as last and `err_overflow` is set.
- START: hold `core_start`=1 for `START_CYC` cycles, then go to RUN.
- RUN:
  - `core_start`=0. `run_cycles` increments every cycle and saturates at 16'hFFFF.
  - `core_done` is sampled only in RUN.
  - `core_done`=1 goes to DONE; `run_cycles` then includes the cycle on which `done` was seen.
  - If `run_cycles` reaches `TIMEOUT` first, set `err_timeout` and go to DONE.
  - If `core_done` and the timeout occur in the same cycle, `done` wins and `err_timeout` stays 0.
- DONE:
  - `complete`=1 for exactly one cycle, then go to IDLE.
  - `core_start` returns to 1 in IDLE.
  - The status outputs hold until the next first accept.
- `core_start` is 1 in IDLE, LOAD and START, so the core never executes a partially loaded program.

## Timing

- Reset values:
  - state IDLE, `core_start`=1, `load_ready`=1.
  - `imem_wr_en`=0, `imem_wr_addr`=0, `imem_wr_data`=0.
  - `complete`=0, `busy`=0, `prog_len`=0, `run_cycles`=0.
  - `err_overflow`=0, `err_timeout`=0.
- Writes are registered: `imem_wr_en`/`addr`/`data` assert on the cycle after the accept, for one cycle. Back-to-back accepts produce back-to-back writes.
- `prog_len` updates on the cycle after the accept.
- The first START cycle is the cycle after the last accept. The last write lands during the first START cycle, before `core_start` falls.
- `core_start` falls exactly `START_CYC` cycles after START is entered.
- `complete` rises on the cycle after `core_done` is sampled in RUN.
- `busy` is registered from the state.
- Reset asserted mid-operation forces all outputs to their reset values immediately, with no clock edge needed. A write pending in the registered stage is dropped.

## Test plan

- **Three-word load:** stream 0x1A5, 0x0FF, 0x100 (last on 0x100) with `load_valid` held high.
  - Writes go to addresses 0, 1, 2 on consecutive cycles; `prog_len`=3.
  - `core_start` falls 2 cycles after the last write.
- **Run with done:** after the three-word load, assert `core_done` 5 cycles after `core_start` falls.
  - `run_cycles`=6, `complete` pulses once, `err_timeout`=0, then IDLE with `core_start`=1.
- **Single word, bursty host:** load a single word with `load_last`=1 in IDLE, with `load_valid` toggling.
  - `prog_len`=1, one write to address 0; no writes occur on cycles where `load_valid`=0.
- **Overflow:** 1025 words with no `load_last`.
  - Writes cover addresses 0–1023; `err_overflow`=1 and `prog_len`=1024.
  - The 1025th word sees `load_ready`=0 until IDLE is re-entered.
- **Timeout:** `TIMEOUT`=20 and `core_done` held 0.
  - `err_timeout`=1 and `run_cycles`=20, `complete` pulses.
  - A `core_done` raised in the same cycle as the timeout instead gives `err_timeout`=0.
- **Reset mid-run:** drop `reset` low during RUN and during LOAD.
  - All outputs take their reset values at once, including `core_start`=1.
  - A new load after release starts at address 0.
